// File: rtl/core_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC            = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {pc, instr} queue with push, pop and single-cycle clear.
module fetch_fifo
    import core_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output fetch_entry_t head_data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    always_comb begin
        empty_o     = (count_q == '0);
        full_o      = (count_q == (AW+1)'(DEPTH));
        do_push     = push_i && !full_o;
        do_pop      = pop_i && !empty_o;
        head_data_o = mem_q[rd_ptr_q];
        count_o     = count_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Instruction-fetch front end: sequential PC generation, in-order memory requests,
// prefetch queue, stall hold and redirect flush with stale-response dropping.
module ifetch_prefetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [15:0] flush_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [15:0]     flush_count_q, flush_count_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    head_entry, push_entry;
    logic [CW:0]     inflight;
    logic            req_valid, accept, rsp_drop, push, pop;

    // Responses come back in issue order and every kept one follows the last
    // redirect sequentially, so a running pc tag replaces a per-request tag queue.
    always_comb begin
        inflight   = {1'b0, outstanding_q} + {1'b0, fifo_count};
        req_valid  = !reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
        accept     = req_valid && imem_req_ready;
        rsp_drop   = imem_rsp_valid && (drop_q != '0);
        push       = imem_rsp_valid && !rsp_drop && !redirect_valid;
        pop        = !fifo_empty && !stall && !redirect_valid;
        push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        flush_count_d = flush_count_q;

        if (accept) fetch_pc_d = fetch_pc_q + PC_INC;

        if (accept && !imem_rsp_valid)      outstanding_d = outstanding_q + CW'(1);
        else if (!accept && imem_rsp_valid) outstanding_d = outstanding_q - CW'(1);

        if (rsp_drop) drop_d   = drop_q - CW'(1);
        if (push)     rsp_pc_d = rsp_pc_q + PC_INC;

        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_target);
            rsp_pc_d   = word_align(redirect_target);
            drop_d     = outstanding_d;
            if (flush_count_q != '1) flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            flush_count_q <= flush_count_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .clear_i     (redirect_valid),
        .head_data_o (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        imem_req_valid = req_valid;
        imem_req_addr  = fetch_pc_q;
        if_valid       = !fifo_empty;
        if_pc          = fifo_empty ? '0 : head_entry.pc;
        if_instr       = fifo_empty ? NOP_INSTR : head_entry.instr;
        flush_count    = flush_count_q;
    end

    rsp_into_full_queue: assert property (@(posedge clock) disable iff (reset)
        !(imem_rsp_valid && fifo_full));

endmodule
